// File: rtl/data_mem.sv
// Single-port register-file data memory: 2^WIDTH words of WIDTH bits,
// synchronous write on CLK, combinational read, asynchronous clear on RST.
module data_mem #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] ADDR,
  input  logic [WIDTH-1:0] D_IN,
  output logic [WIDTH-1:0] D_OUT
);

  localparam int unsigned DEPTH = 2 ** WIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_d;

  // An unknown address must not scribble on an arbitrary word in simulation.
  always_comb begin
    wr_d = EN && !$isunknown(ADDR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_q <= '{default: '0};
    end else if (wr_d) begin
      mem_q[ADDR] <= D_IN;
    end
  end

  // Read is purely combinational, so the current word stays visible up to the
  // write edge and the new value appears right after it.
  assign D_OUT = mem_q[ADDR];

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem (WIDTH=8): vector table, directed corner
// sequences and randomized traffic against an array reference model.
module tb_data_mem;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic [7:0] ADDR;
  logic [7:0] D_IN;
  logic [7:0] D_OUT;

  int unsigned checks;
  int unsigned errors;
  logic [7:0]  model [256];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] din;
    logic       en;
    logic [7:0] exp_pre;
    logic [7:0] exp_post;
  } vec_t;

  vec_t vecs [7];

  data_mem #(.WIDTH(8)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .ADDR (ADDR),
    .D_IN (D_IN),
    .D_OUT(D_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at t=%0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check read before and after the rising edge.
  task automatic cycle(input string name, input logic [7:0] a, input logic [7:0] d,
                       input logic e, input logic [7:0] exp_pre, input logic [7:0] exp_post);
    @(negedge CLK);
    ADDR = a;
    D_IN = d;
    EN   = e;
    #1 check({name, "_pre"}, D_OUT, exp_pre);
    @(posedge CLK);
    #1 check({name, "_post"}, D_OUT, exp_post);
  endtask

  task automatic sweep(input string name);
    @(negedge CLK);
    EN = 1'b0;
    for (int a = 0; a < 256; a++) begin
      ADDR = 8'(a);
      #1 check(name, D_OUT, model[a]);
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < 256; a++) model[a] = 8'h00;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{addr: 8'h10, din: 8'hAA, en: 1'b1, exp_pre: 8'h50, exp_post: 8'hAA};
    vecs[1] = '{addr: 8'h10, din: 8'h55, en: 1'b0, exp_pre: 8'hAA, exp_post: 8'hAA};
    vecs[2] = '{addr: 8'h20, din: 8'h11, en: 1'b1, exp_pre: 8'hA0, exp_post: 8'h11};
    vecs[3] = '{addr: 8'h20, din: 8'h22, en: 1'b1, exp_pre: 8'h11, exp_post: 8'h22};
    vecs[4] = '{addr: 8'hFF, din: 8'h7F, en: 1'b1, exp_pre: 8'hFB, exp_post: 8'h7F};
    vecs[5] = '{addr: 8'h00, din: 8'hC3, en: 1'b1, exp_pre: 8'h00, exp_post: 8'hC3};
    vecs[6] = '{addr: 8'h01, din: 8'h99, en: 1'b0, exp_pre: 8'h05, exp_post: 8'h05};

    // Reset and blank sweep
    RST = 1'b1; EN = 1'b0; ADDR = 8'h37; D_IN = 8'hFF;
    model_clear();
    #1 check("reset_dout", D_OUT, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    sweep("blank_sweep");

    // Fill pattern 5*addr, one write every 5 cycles
    for (int a = 0; a < 256; a++) begin
      @(negedge CLK);
      ADDR = 8'(a);
      D_IN = 8'(5 * a);
      EN   = 1'b1;
      model[a] = 8'(5 * a);
      @(negedge CLK);
      EN = 1'b0;
      repeat (3) @(negedge CLK);
    end
    sweep("pattern_sweep");
    @(negedge CLK);
    ADDR = 8'h00; #1 check("pattern_a00", D_OUT, 8'h00);
    ADDR = 8'h01; #1 check("pattern_a01", D_OUT, 8'h05);
    ADDR = 8'h02; #1 check("pattern_a02", D_OUT, 8'h0A);
    ADDR = 8'hFF; #1 check("pattern_aFF", D_OUT, 8'hFB);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].addr, vecs[i].din, vecs[i].en,
            vecs[i].exp_pre, vecs[i].exp_post);
      if (vecs[i].en) model[vecs[i].addr] = vecs[i].din;
    end

    // Hold EN=0 with different D_IN for 20 cycles
    for (int i = 0; i < 20; i++) cycle("hold_0x10", 8'h10, 8'h55, 1'b0, 8'hAA, 8'hAA);

    // Inputs change between edges: only the values present at the edge count
    @(negedge CLK);
    ADDR = 8'h30; D_IN = 8'h01; EN = 1'b1;
    #2 ADDR = 8'h31; D_IN = 8'h02;
    @(posedge CLK);
    #1 EN = 1'b0;
    model[8'h31] = 8'h02;
    ADDR = 8'h30; #1 check("midcycle_0x30", D_OUT, 8'hF0);
    ADDR = 8'h31; #1 check("midcycle_0x31", D_OUT, 8'h02);

    // Back-to-back writes
    @(negedge CLK);
    EN = 1'b1; ADDR = 8'h03; D_IN = 8'h01;
    @(negedge CLK);
    ADDR = 8'h04; D_IN = 8'h02;
    @(negedge CLK);
    ADDR = 8'h05; D_IN = 8'h03;
    @(negedge CLK);
    EN = 1'b0;
    model[3] = 8'h01; model[4] = 8'h02; model[5] = 8'h03;
    ADDR = 8'h03; #1 check("b2b_a3", D_OUT, 8'h01);
    ADDR = 8'h04; #1 check("b2b_a4", D_OUT, 8'h02);
    ADDR = 8'h05; #1 check("b2b_a5", D_OUT, 8'h03);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      logic [7:0] d;
      logic       e;
      logic [7:0] pre;
      a = 8'($urandom_range(255));
      d = 8'($urandom);
      e = ($urandom_range(3) != 0);
      pre = model[a];
      if (e) model[a] = d;
      cycle("rand", a, d, e, pre, model[a]);
    end
    sweep("rand_sweep");

    // Asynchronous reset between edges
    cycle("pre_rst_wr", 8'hFF, 8'h7F, 1'b1, model[8'hFF], 8'h7F);
    @(negedge CLK);
    EN = 1'b0; ADDR = 8'hFF;
    #2 RST = 1'b1;
    model_clear();
    #1 check("async_rst_aFF", D_OUT, 8'h00);
    ADDR = 8'h10; #1 check("async_rst_a10", D_OUT, 8'h00);

    // Writes blocked while RST is held
    cycle("rst_block", 8'h40, 8'h5A, 1'b1, 8'h00, 8'h00);
    @(negedge CLK);
    EN = 1'b0;
    RST = 1'b0;
    #1 check("rst_block_after", D_OUT, 8'h00);

    // First write after release
    cycle("post_rst_wr", 8'h40, 8'h3C, 1'b1, 8'h00, 8'h3C);
    model[8'h40] = 8'h3C;
    sweep("post_rst_sweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
